// File: rtl/replay_pkg.sv
// Shared types and helpers for the replay-run controller.
package replay_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Index width for a channel select; a single channel still gets one bit.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Code reported when the run ends on the cycle limit; callers truncate to CODE_W.
  function automatic logic [255:0] timeout_code();
    return '1;
  endfunction

endpackage

// File: rtl/replay_exit_arb.sv
// Lowest-index-wins priority encoder over the exit-request channels.
module replay_exit_arb
  import replay_pkg::*;
#(
  parameter int NUM_CHAN = 4,
  parameter int CODE_W   = 8,
  localparam int CHAN_W  = chan_w(NUM_CHAN)
) (
  input  logic [NUM_CHAN-1:0]        req_i,
  input  logic [NUM_CHAN*CODE_W-1:0] code_i,
  output logic                       vld_o,
  output logic [CHAN_W-1:0]          idx_o,
  output logic [CODE_W-1:0]          code_o
);

  // Scan high to low so the lowest requesting index is the last to write.
  always_comb begin
    vld_o  = 1'b0;
    idx_o  = '0;
    code_o = '0;
    for (int i = NUM_CHAN-1; i >= 0; i--) begin
      if (req_i[i]) begin
        vld_o  = 1'b1;
        idx_o  = CHAN_W'(i);
        code_o = code_i[i*CODE_W +: CODE_W];
      end
    end
  end

endmodule

// File: rtl/replay_sequencer.sv
// Replay-run controller: DUT reset sequencing, run cycle count, dump window,
// exit arbitration with optional cycle-limit timeout and post-exit drain.
module replay_sequencer
  import replay_pkg::*;
#(
  parameter int NUM_CHAN     = 4,
  parameter int CYCLE_W      = 64,
  parameter int CODE_W       = 8,
  parameter int RESET_CYCLES = 5,
  parameter int DRAIN_CYCLES = 2,
  localparam int CHAN_W      = chan_w(NUM_CHAN)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [CYCLE_W-1:0]         max_cycles,
  input  logic [CYCLE_W-1:0]         dump_start,
  input  logic [CYCLE_W-1:0]         dump_stop,
  input  logic [NUM_CHAN-1:0]        exit_req,
  input  logic [NUM_CHAN*CODE_W-1:0] exit_code_in,
  output logic                       dut_reset,
  output logic [CYCLE_W-1:0]         cycles,
  output logic                       dump_en,
  output logic                       exit,
  output logic [CODE_W-1:0]          exit_code,
  output logic [CHAN_W-1:0]          exit_chan,
  output logic                       timeout,
  output logic [1:0]                 state
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CODE_W-1:0] TIMEOUT_CODE = CODE_W'(timeout_code());

  state_e              state_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [DRN_W-1:0]    drain_q;
  logic [CYCLE_W-1:0]  cycles_q, cycles_d;
  logic                dut_reset_q, dump_en_q, exit_q, timeout_q;
  logic [CODE_W-1:0]   code_q;
  logic [CHAN_W-1:0]   chan_q;

  logic                arb_vld;
  logic [CHAN_W-1:0]   arb_idx;
  logic [CODE_W-1:0]   arb_code;
  logic                in_win, tmo_hit;

  replay_exit_arb #(.NUM_CHAN(NUM_CHAN), .CODE_W(CODE_W)) u_arb (
    .req_i  (exit_req),
    .code_i (exit_code_in),
    .vld_o  (arb_vld),
    .idx_o  (arb_idx),
    .code_o (arb_code)
  );

  // Window and limit compares use the registered count, so dump_en lags by one edge.
  assign in_win   = (cycles_q >= dump_start) && (cycles_q < dump_stop);
  assign tmo_hit  = (max_cycles != '0) && (cycles_q >= max_cycles);
  assign cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + CYCLE_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HOLD;
      hold_q      <= '0;
      drain_q     <= '0;
      cycles_q    <= '0;
      dut_reset_q <= 1'b1;
      dump_en_q   <= 1'b0;
      exit_q      <= 1'b0;
      timeout_q   <= 1'b0;
      code_q      <= '0;
      chan_q      <= '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_q == HOLD_W'(RESET_CYCLES-1)) begin
            state_q     <= RUN;
            dut_reset_q <= 1'b0;
            dump_en_q   <= in_win;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        RUN: begin
          cycles_q <= cycles_d;
          if (arb_vld || tmo_hit) begin
            // A real request beats the limit when both land on the same edge.
            code_q    <= arb_vld ? arb_code : TIMEOUT_CODE;
            chan_q    <= arb_vld ? arb_idx : '0;
            timeout_q <= !arb_vld;
            drain_q   <= '0;
            if (DRAIN_CYCLES == 0) begin
              state_q   <= DONE;
              exit_q    <= 1'b1;
              dump_en_q <= 1'b0;
            end else begin
              state_q   <= DRAIN;
              dump_en_q <= in_win;
            end
          end else begin
            dump_en_q <= in_win;
          end
        end
        DRAIN: begin
          cycles_q <= cycles_d;
          if (drain_q == DRN_W'(DRAIN_CYCLES-1)) begin
            state_q   <= DONE;
            exit_q    <= 1'b1;
            dump_en_q <= 1'b0;
          end else begin
            drain_q   <= drain_q + DRN_W'(1);
            dump_en_q <= in_win;
          end
        end
        default: dump_en_q <= 1'b0;
      endcase
    end
  end

  assign dut_reset = dut_reset_q;
  assign cycles    = cycles_q;
  assign dump_en   = dump_en_q;
  assign exit      = exit_q;
  assign exit_code = code_q;
  assign exit_chan = chan_q;
  assign timeout   = timeout_q;
  assign state     = state_q;

endmodule

// File: tb/tb_replay_sequencer.sv
// Directed bench for replay_sequencer; exit results are checked by a scoreboard monitor.
module tb_replay_sequencer;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, rst_z;
  logic [63:0] max_cycles, dump_start, dump_stop;
  logic [3:0]  exit_req, req_z;
  logic [31:0] codes;

  logic        dut_reset, dump_en, exit_a, timeout;
  logic [63:0] cycles;
  logic [7:0]  exit_code;
  logic [1:0]  exit_chan, state;

  logic        dut_reset_z, dump_en_z, exit_z, timeout_z;
  logic [63:0] cycles_z;
  logic [7:0]  exit_code_z;
  logic [1:0]  exit_chan_z, state_z;

  replay_sequencer u_dut (
    .clock(clock), .reset(reset), .max_cycles(max_cycles),
    .dump_start(dump_start), .dump_stop(dump_stop),
    .exit_req(exit_req), .exit_code_in(codes),
    .dut_reset(dut_reset), .cycles(cycles), .dump_en(dump_en), .exit(exit_a),
    .exit_code(exit_code), .exit_chan(exit_chan), .timeout(timeout), .state(state)
  );

  replay_sequencer #(.DRAIN_CYCLES(0)) u_dz (
    .clock(clock), .reset(rst_z), .max_cycles(max_cycles),
    .dump_start(dump_start), .dump_stop(dump_stop),
    .exit_req(req_z), .exit_code_in(codes),
    .dut_reset(dut_reset_z), .cycles(cycles_z), .dump_en(dump_en_z), .exit(exit_z),
    .exit_code(exit_code_z), .exit_chan(exit_chan_z), .timeout(timeout_z), .state(state_z)
  );

  typedef struct {
    logic [7:0]  code;
    logic [1:0]  chan;
    logic        tmo;
    logic [63:0] cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_z[$];
  exp_t ea, ez;
  int   n_chk = 0;
  int   n_pass = 0;
  logic prev_a = 1'b0;
  logic prev_z = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitors: every rising exit pops one expected result.
  always @(negedge clock) begin
    if (exit_a && !prev_a) begin
      if (q_a.size() == 0) begin
        n_chk++;
        $display("FAIL exit_a_unexpected: exit rose with no expected result queued");
      end else begin
        ea = q_a.pop_front();
        chk("sb_a_code",  64'(exit_code), 64'(ea.code));
        chk("sb_a_chan",  64'(exit_chan), 64'(ea.chan));
        chk("sb_a_tmo",   64'(timeout),   64'(ea.tmo));
        chk("sb_a_cycles", cycles,        ea.cyc);
      end
    end
    prev_a = exit_a;
  end

  always @(negedge clock) begin
    if (exit_z && !prev_z) begin
      if (q_z.size() == 0) begin
        n_chk++;
        $display("FAIL exit_z_unexpected: exit rose with no expected result queued");
      end else begin
        ez = q_z.pop_front();
        chk("sb_z_code",  64'(exit_code_z), 64'(ez.code));
        chk("sb_z_chan",  64'(exit_chan_z), 64'(ez.chan));
        chk("sb_z_tmo",   64'(timeout_z),   64'(ez.tmo));
        chk("sb_z_cycles", cycles_z,        ez.cyc);
      end
    end
    prev_z = exit_z;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_state"},     64'(state),     64'd0);
    chk({tag, "_dut_reset"}, 64'(dut_reset), 64'd1);
    chk({tag, "_cycles"},    cycles,         64'd0);
    chk({tag, "_dump_en"},   64'(dump_en),   64'd0);
    chk({tag, "_exit"},      64'(exit_a),    64'd0);
    chk({tag, "_code"},      64'(exit_code), 64'd0);
    chk({tag, "_chan"},      64'(exit_chan), 64'd0);
    chk({tag, "_timeout"},   64'(timeout),   64'd0);
  endtask

  // Release reset and expect exactly 5 edges of dut_reset before RUN.
  task automatic hold_seq(input string tag);
    int bad = 0;
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (dut_reset !== (i < 5)) bad++;
      if (state !== ((i < 5) ? 2'd0 : 2'd1)) bad++;
    end
    chk({tag, "_hold_seq"}, 64'(bad), 64'd0);
    chk({tag, "_run_cycles0"}, cycles, 64'd0);
  endtask

  task automatic wait_exit_a(input int bound);
    int n = 0;
    while (!exit_a && n < bound) begin
      tick();
      n++;
    end
    if (!exit_a) begin
      n_chk++;
      $display("FAIL exit_a_wait: exit=0 expected 1 within %0d cycles", bound);
    end
  endtask

  initial begin
    int errs, derr, dhi;
    reset = 1'b1; rst_z = 1'b1;
    max_cycles = 64'd0; dump_start = 64'd3; dump_stop = 64'd6;
    exit_req = 4'b0; req_z = 4'b0;
    codes = {8'h33, 8'hCC, 8'h11, 8'hAA};
    tick(); tick();
    chk_reset("t0");

    // Free run with dump window 3..6.
    hold_seq("t1");
    errs = 0; derr = 0; dhi = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (cycles !== 64'(k)) errs++;
      if (exit_a !== 1'b0) errs++;
      if (dump_en !== (k >= 4 && k <= 6)) derr++;
      if (dump_en) dhi++;
    end
    chk("t1_cycles_100", cycles, 64'd100);
    chk("t1_run_errs", 64'(errs), 64'd0);
    chk("t1_dump_window", 64'(derr), 64'd0);
    chk("t1_dump_count", 64'(dhi), 64'd3);

    // Cycle-limit timeout, inverted dump window.
    reset = 1'b1; max_cycles = 64'd10; dump_start = 64'd6; dump_stop = 64'd3;
    tick();
    q_a.push_back('{8'hFF, 2'd0, 1'b1, 64'd13});
    hold_seq("t2");
    dhi = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (dump_en) dhi++;
      if (k == 10) chk("t2_run_at_10", 64'(state), 64'd1);
    end
    chk("t2_drain_entry", 64'(state), 64'd2);
    chk("t2_drain_cycles", cycles, 64'd11);
    wait_exit_a(10);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (dump_en) dhi++;
    end
    chk("t2_done_state", 64'(state), 64'd3);
    chk("t2_cycles_frozen", cycles, 64'd13);
    chk("t2_timeout", 64'(timeout), 64'd1);
    chk("t2_dump_never", 64'(dhi), 64'd0);

    // Arbitration: channels 1 and 3 request, 1 wins.
    reset = 1'b1; max_cycles = 64'd0; dump_start = 64'd3; dump_stop = 64'd6;
    tick();
    hold_seq("t3");
    q_a.push_back('{8'h11, 2'd1, 1'b0, 64'd23});
    repeat (20) tick();
    exit_req = 4'b1010;
    tick();
    chk("t3_drain_entry", 64'(state), 64'd2);
    chk("t3_drain_cycles", cycles, 64'd21);
    exit_req = 4'b0;
    tick();
    chk("t3_exit_not_yet", 64'(exit_a), 64'd0);
    tick();
    chk("t3_exit_latency", 64'(exit_a), 64'd1);
    tick();

    // Request and limit on the same edge; later requests ignored.
    reset = 1'b1; max_cycles = 64'd15;
    tick();
    hold_seq("t4");
    q_a.push_back('{8'hCC, 2'd2, 1'b0, 64'd18});
    repeat (15) tick();
    exit_req = 4'b0100;
    tick();
    chk("t4_drain_entry", 64'(state), 64'd2);
    exit_req = 4'b0001;
    tick();
    exit_req = 4'b1000;
    tick();
    exit_req = 4'b0011;
    repeat (3) tick();
    chk("t4_chan_kept", 64'(exit_chan), 64'd2);
    chk("t4_code_kept", 64'(exit_code), 64'hCC);
    chk("t4_timeout", 64'(timeout), 64'd0);
    chk("t4_done", 64'(state), 64'd3);
    chk("t4_cycles", cycles, 64'd18);

    // Reset out of DONE, then a reset pulse mid-run.
    exit_req = 4'b0; max_cycles = 64'd0; dump_start = 64'd0; dump_stop = 64'd100;
    reset = 1'b1;
    tick();
    chk_reset("t5_from_done");
    hold_seq("t5a");
    repeat (7) tick();
    chk("t5_cycles7", cycles, 64'd7);
    chk("t5_dump_hi", 64'(dump_en), 64'd1);
    reset = 1'b1;
    tick();
    chk_reset("t5_mid");
    hold_seq("t5b");
    repeat (3) tick();
    chk("t5_rerun_cycles", cycles, 64'd3);

    // Zero-drain instance: exit on the edge after the request.
    reset = 1'b1;
    rst_z = 1'b0;
    repeat (5) tick();
    chk("t6_run", 64'(state_z), 64'd1);
    q_z.push_back('{8'h33, 2'd3, 1'b0, 64'd6});
    repeat (5) tick();
    req_z = 4'b1000;
    tick();
    chk("t6_exit_latency", 64'(exit_z), 64'd1);
    chk("t6_done", 64'(state_z), 64'd3);
    req_z = 4'b0;
    tick(); tick();

    chk("pending_exits_a", 64'(q_a.size()), 64'd0);
    chk("pending_exits_z", 64'(q_z.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
